// File: rtl/demux_escrita.sv
`default_nettype none
// ============================================================================
//  Module   : demux_escrita
//  Purpose  : 1:N write demultiplexer. Latches a data word into one of N_OUT
//             holding slots, each with a valid flag and per-slot acknowledge.
//  Revision : 1.0  initial release
// ============================================================================
module demux_escrita #(
    parameter int DATA_W = 64,
    parameter int N_OUT  = 7,
    parameter int SEL_W  = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [DATA_W-1:0]         entrada,
    input  logic [SEL_W-1:0]          seletor,
    input  logic                      escreve,
    output logic                      pronto,
    output logic [N_OUT*DATA_W-1:0]   saida,
    output logic [N_OUT-1:0]          valido,
    input  logic [N_OUT-1:0]          ack,
    output logic [2:0]                ocupados,
    output logic                      erro,
    input  logic                      limpa_erro
);

    logic [DATA_W-1:0] r_dados [N_OUT];
    logic [N_OUT-1:0]  r_valido;
    logic [2:0]        r_ocupados;
    logic              r_erro;

    logic              w_sel_ok;
    logic [N_OUT-1:0]  w_livre;
    logic              w_livre_sel;
    logic              w_pronto;
    logic [N_OUT-1:0]  w_wr;
    logic [N_OUT-1:0]  w_valido_nxt;
    logic              w_ilegal;

    function automatic logic [2:0] f_conta(input logic [N_OUT-1:0] v);
        logic [2:0] s;
        s = '0;
        for (int i = 0; i < N_OUT; i++) begin
            s = s + {2'b00, v[i]};
        end
        return s;
    endfunction

    assign w_sel_ok = (seletor < SEL_W'(N_OUT));
    // A slot can take a new word if it is empty or being drained this cycle.
    assign w_livre  = ~r_valido | ack;

    // Loop-based lookup keeps illegal selector values from indexing out of range.
    always_comb begin
        w_livre_sel = 1'b0;
        for (int i = 0; i < N_OUT; i++) begin
            if (seletor == SEL_W'(i)) begin
                w_livre_sel = w_livre[i];
            end
        end
    end

    assign w_pronto = w_sel_ok && w_livre_sel;
    assign w_ilegal = escreve && !w_sel_ok;

    always_comb begin
        w_wr = '0;
        for (int i = 0; i < N_OUT; i++) begin
            w_wr[i] = escreve && w_pronto && (seletor == SEL_W'(i));
        end
    end

    // Write wins over a simultaneous ack on the same slot.
    assign w_valido_nxt = (r_valido & ~ack) | w_wr;

    generate
        for (genvar gi = 0; gi < N_OUT; gi++) begin : g_slot
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_dados[gi] <= '0;
                end else if (w_wr[gi]) begin
                    r_dados[gi] <= entrada;
                end
            end
            assign saida[gi*DATA_W +: DATA_W] = r_dados[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valido   <= '0;
            r_ocupados <= '0;
        end else begin
            r_valido   <= w_valido_nxt;
            r_ocupados <= f_conta(w_valido_nxt);
        end
    end

    // Set has priority over clear so an error in the clear cycle is not lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_erro <= 1'b0;
        end else if (w_ilegal) begin
            r_erro <= 1'b1;
        end else if (limpa_erro) begin
            r_erro <= 1'b0;
        end
    end

    assign pronto   = w_pronto;
    assign valido   = r_valido;
    assign ocupados = r_ocupados;
    assign erro     = r_erro;

endmodule
`default_nettype wire

// File: tb/tb_demux_escrita.sv
`default_nettype none
// Directed bench for demux_escrita: reference model of slots/valid/error plus
// a scoreboard of accepted writes checked when the data lands.
module tb_demux_escrita;

    localparam int DATA_W = 64;
    localparam int N_OUT  = 7;
    localparam int SEL_W  = 4;

    logic                    clk;
    logic                    reset_n;
    logic [DATA_W-1:0]       entrada;
    logic [SEL_W-1:0]        seletor;
    logic                    escreve;
    logic                    pronto;
    logic [N_OUT*DATA_W-1:0] saida;
    logic [N_OUT-1:0]        valido;
    logic [N_OUT-1:0]        ack;
    logic [2:0]              ocupados;
    logic                    erro;
    logic                    limpa_erro;

    demux_escrita #(.DATA_W(DATA_W), .N_OUT(N_OUT), .SEL_W(SEL_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .entrada    (entrada),
        .seletor    (seletor),
        .escreve    (escreve),
        .pronto     (pronto),
        .saida      (saida),
        .valido     (valido),
        .ack        (ack),
        .ocupados   (ocupados),
        .erro       (erro),
        .limpa_erro (limpa_erro)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          slot;
        logic [63:0] data;
    } sb_t;

    sb_t         sb[$];
    logic [63:0] m_data [N_OUT];
    logic [6:0]  m_valido;
    logic        m_erro;
    int          n_chk;
    int          n_pass;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic chk_state(input string tag);
        chk({tag, ".valido"},   64'(valido),   64'(m_valido));
        chk({tag, ".ocupados"}, 64'(ocupados), 64'($countones(m_valido)));
        chk({tag, ".erro"},     64'(erro),     64'(m_erro));
        for (int i = 0; i < N_OUT; i++) begin
            chk($sformatf("%s.slot%0d", tag, i), saida[i*DATA_W +: DATA_W], m_data[i]);
        end
    endtask

    // One clock cycle of stimulus, with pronto checked before the edge and
    // all state checked just after it.
    task automatic cycle(input string tag, input logic esc, input logic [3:0] sel,
                         input logic [63:0] d, input logic [6:0] a, input logic lim);
        logic exp_pronto;
        logic wr;
        sb_t  e;
        escreve    = esc;
        seletor    = sel;
        entrada    = d;
        ack        = a;
        limpa_erro = lim;
        #1;
        exp_pronto = (sel < 4'd7) && (!m_valido[sel[2:0]] || a[sel[2:0]]);
        chk({tag, ".pronto"}, 64'(pronto), 64'(exp_pronto));
        wr = esc && exp_pronto;
        if (wr) sb.push_back('{int'(sel), d});
        m_valido = m_valido & ~a;
        if (wr) begin
            m_valido[sel[2:0]] = 1'b1;
            m_data[sel[2:0]]   = d;
        end
        if (esc && sel >= 4'd7) m_erro = 1'b1;
        else if (lim)           m_erro = 1'b0;
        @(posedge clk);
        #1;
        escreve    = 1'b0;
        ack        = '0;
        limpa_erro = 1'b0;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, ".sb_data"},  saida[e.slot*DATA_W +: DATA_W], e.data);
            chk({tag, ".sb_valid"}, 64'(valido[e.slot]), 64'd1);
        end
        chk_state(tag);
    endtask

    task automatic model_reset();
        for (int i = 0; i < N_OUT; i++) m_data[i] = '0;
        m_valido = '0;
        m_erro   = 1'b0;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        reset_n    = 1'b0;
        entrada    = '0;
        seletor    = '0;
        escreve    = 1'b0;
        ack        = '0;
        limpa_erro = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_state("reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic write into slot 2
        cycle("wr2", 1'b1, 4'd2, 64'hDEAD_BEEF_0000_0001, 7'h00, 1'b0);
        // Full slot: rejected, then accepted together with its ack
        cycle("full", 1'b1, 4'd2, 64'h5, 7'h00, 1'b0);
        cycle("wr_ack", 1'b1, 4'd2, 64'h5, 7'b0000100, 1'b0);
        cycle("drain2", 1'b0, 4'd0, 64'h0, 7'b0000100, 1'b0);

        // Fill every slot, then drain all at once
        for (int i = 0; i < N_OUT; i++) begin
            cycle($sformatf("fill%0d", i), 1'b1, 4'(i), 64'(10 + i), 7'h00, 1'b0);
        end
        cycle("ack_all", 1'b0, 4'd0, 64'h0, 7'h7F, 1'b0);

        // Illegal selectors and sticky error
        cycle("ill_idle", 1'b0, 4'd12, 64'h77, 7'h00, 1'b0);
        cycle("ill9", 1'b1, 4'd9, 64'h99, 7'h00, 1'b0);
        cycle("ill9_clr", 1'b1, 4'd9, 64'h99, 7'h00, 1'b1);
        cycle("clr", 1'b0, 4'd0, 64'h0, 7'h00, 1'b1);
        cycle("ill7", 1'b1, 4'd7, 64'h7, 7'h00, 1'b0);
        cycle("clr2", 1'b0, 4'd0, 64'h0, 7'h00, 1'b1);

        // Ack to an empty slot is ignored
        cycle("ack_empty", 1'b0, 4'd0, 64'h0, 7'b0010000, 1'b0);

        // Boundary slot 6 plus mixed write/ack on different slots
        cycle("wr6", 1'b1, 4'd6, 64'hFFFF_FFFF_FFFF_FFFF, 7'h00, 1'b0);
        cycle("wr0_ack6", 1'b1, 4'd0, 64'h1234_5678_9ABC_DEF0, 7'b1000000, 1'b0);

        // Asynchronous reset between edges
        cycle("wr1", 1'b1, 4'd1, 64'hA1, 7'h00, 1'b0);
        cycle("wr3", 1'b1, 4'd3, 64'hA3, 7'h00, 1'b1);
        cycle("ill_pre_rst", 1'b1, 4'd15, 64'h0, 7'h00, 1'b0);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        model_reset();
        chk_state("async_rst");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        cycle("post_rst", 1'b1, 4'd5, 64'hC0FFEE, 7'h00, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
